// File: rtl/ext_sram_ctrl_pkg.sv
// ext_sram_ctrl_pkg: shared definitions for the external SRAM slave controller.
// Holds the FSM state encoding, default geometry constants, the error fill
// word and the byte-merge helper used by the storage array.
package ext_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        EXT_SRAM_IDLE   = 2'd0,
        EXT_SRAM_WAIT   = 2'd1,
        EXT_SRAM_ACCESS = 2'd2
    } ext_sram_state_t;

    localparam logic [31:0] EXT_SRAM_BASE     = 32'h8000_0000;
    localparam int unsigned EXT_SRAM_DEPTH    = 4096;
    localparam logic [31:0] EXT_SRAM_ERR_DATA = 32'hDEAD_BEEF;

    // Replace each byte lane of old_word whose strobe bit is set with the
    // corresponding lane of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/ext_sram_array.sv
// ext_sram_array: single-port synchronous word RAM with per-byte write enables
// and a registered read port. The read register only loads when re is high,
// so it holds the last value read between read accesses. A combined write and
// read returns the merged post-write word (write-first).
module ext_sram_array
    import ext_sram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = EXT_SRAM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [3:0]               wstrb,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              q
);

    logic [31:0] mem [DEPTH];
    logic [31:0] merged;

    assign merged = merge_bytes(mem[addr], wdata, we ? wstrb : 4'b0000);

    // Byte-lane writes into the storage array.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && wstrb[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered read port, loaded only on read accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (re) begin
            q <= merged;
        end
    end

endmodule

// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl: slave controller servicing memory_controller's ext_* port
// from an on-chip word SRAM, with WAIT_STATES programmable wait cycles.
// Optional feature: define EXT_SRAM_BOUNDS_EN to range-check addresses
// against [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS); out-of-range writes are
// dropped, out-of-range reads return EXT_SRAM_ERR_DATA and ext_err pulses.
// Without it, the word index wraps modulo DEPTH_WORDS and ext_err is 0.
module ext_sram_ctrl
    import ext_sram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = EXT_SRAM_DEPTH,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = EXT_SRAM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_wstrb,
    input  logic        ext_we,
    input  logic        ext_re,
    output logic [31:0] ext_rdata,
    output logic        ext_ready,
    output logic        ext_err,
    output logic        busy
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    ext_sram_state_t state;
    logic [3:0]      cnt;
    logic            ready;

    logic [31:0] addr_lat;
    logic [31:0] wdata_lat;
    logic [3:0]  wstrb_lat;
    logic        we_lat;
    logic        re_lat;

    logic        req;
    logic        go;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_we;
    logic        acc_re;
    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        oor;
    logic [31:0] q;

    assign req = ext_we | ext_re;

    // Access operands: live inputs when a zero-wait request is accepted in
    // IDLE, otherwise the copy latched at acceptance. go marks the ACCESS edge;
    // reset on that edge abandons the access so nothing is committed.
    always_comb begin
        go        = 1'b0;
        acc_addr  = addr_lat;
        acc_wdata = wdata_lat;
        acc_wstrb = wstrb_lat;
        acc_we    = we_lat;
        acc_re    = re_lat;
        if (state == EXT_SRAM_IDLE) begin
            go        = req && (WAIT_STATES == 0);
            acc_addr  = ext_addr;
            acc_wdata = ext_wdata;
            acc_wstrb = ext_wstrb;
            acc_we    = ext_we;
            acc_re    = ext_re;
        end else if (state == EXT_SRAM_WAIT) begin
            go = (cnt == 4'd0);
        end
        if (rst) begin
            go = 1'b0;
        end
    end

    // Word index in 32-bit modulo arithmetic; truncation gives the wrap.
    assign offset = acc_addr - BASE_ADDR;
    assign idx    = AW'(offset >> 2);

`ifdef EXT_SRAM_BOUNDS_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    assign oor = ({1'b0, offset} >= SPAN);
`else
    assign oor = 1'b0;
`endif

    ext_sram_array #(
        .DEPTH (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (go & acc_we & ~oor),
        .re    (go & acc_re & ~oor),
        .wstrb (acc_wstrb),
        .addr  (idx),
        .wdata (acc_wdata),
        .q     (q)
    );

    // Control FSM: IDLE -> WAIT -> ACCESS -> IDLE, with registered ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EXT_SRAM_IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
        end else begin
            ready <= go;
            case (state)
                EXT_SRAM_IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state <= EXT_SRAM_ACCESS;
                        end else begin
                            state <= EXT_SRAM_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                EXT_SRAM_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= EXT_SRAM_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                EXT_SRAM_ACCESS: state <= EXT_SRAM_IDLE;
                default:         state <= EXT_SRAM_IDLE;
            endcase
        end
    end

    // Capture the request at acceptance; inputs are ignored until IDLE again.
    always_ff @(posedge clk) begin
        if (state == EXT_SRAM_IDLE && req) begin
            addr_lat  <= ext_addr;
            wdata_lat <= ext_wdata;
            wstrb_lat <= ext_wstrb;
            we_lat    <= ext_we;
            re_lat    <= ext_re;
        end
    end

    assign ext_ready = ready;
    assign busy      = (state != EXT_SRAM_IDLE);

`ifdef EXT_SRAM_BOUNDS_EN
    logic err;
    logic rd_err;

    // Error pulse with ready; rd_err remembers whether the last read was
    // out of range so the fill word is held like any other read result.
    always_ff @(posedge clk) begin
        if (rst) begin
            err    <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            err <= go & oor;
            if (go & acc_re) begin
                rd_err <= oor;
            end
        end
    end

    assign ext_err   = err;
    assign ext_rdata = rd_err ? EXT_SRAM_ERR_DATA : q;
`else
    assign ext_err   = 1'b0;
    assign ext_rdata = q;
`endif

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// tb_ext_sram_ctrl: bench for ext_sram_ctrl. Instance a uses WAIT_STATES=2,
// instance b uses WAIT_STATES=0; both share clock and reset. Expected data
// comes from a word-array model indexed by ((addr-BASE)/4) mod DEPTH.
module tb_ext_sram_ctrl;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] ERRW  = 32'hDEAD_BEEF;
`ifdef EXT_SRAM_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
    logic [3:0]  a_wstrb, b_wstrb;
    logic        a_we, a_re, a_ready, a_err, a_busy;
    logic        b_we, b_re, b_ready, b_err, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] last_rd [2];

    ext_sram_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .rst(rst), .ext_addr(a_addr), .ext_wdata(a_wdata), .ext_wstrb(a_wstrb),
        .ext_we(a_we), .ext_re(a_re), .ext_rdata(a_rdata), .ext_ready(a_ready),
        .ext_err(a_err), .busy(a_busy));

    ext_sram_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .rst(rst), .ext_addr(b_addr), .ext_wdata(b_wdata), .ext_wstrb(b_wstrb),
        .ext_we(b_we), .ext_re(b_re), .ext_rdata(b_rdata), .ext_ready(b_ready),
        .ext_err(b_err), .busy(b_busy));

    // Reference: plain word array, byte merge, held read register.
    function automatic void model_txn(input int s, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] strb, input logic we, input logic re,
                                      output logic [31:0] exp_rd, output logic exp_err);
        logic [31:0] off;
        int          idx;
        off = addr - BASE;
        idx = int'((off / 32'd4) % 32'(DEPTH));
        if (BOUNDS && (off >= 32'(4 * DEPTH))) begin
            exp_err = 1'b1;
            if (re) last_rd[s] = ERRW;
        end else begin
            exp_err = 1'b0;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem_m[s][idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (re) last_rd[s] = mem_m[s][idx];
        end
        exp_rd = last_rd[s];
    endfunction

    task automatic drive(input int s, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic we, input logic re);
        if (s == 0) begin
            a_addr = addr; a_wdata = wdata; a_wstrb = strb; a_we = we; a_re = re;
        end else begin
            b_addr = addr; b_wdata = wdata; b_wstrb = strb; b_we = we; b_re = re;
        end
    endtask

    // One transaction: request held until ready is seen (bounded), then dropped.
    // lat = cycles from first request cycle to ready (-1 on timeout);
    // bt[k] = busy in cycle T+k; rdy_after = ready in the cycle after the pulse.
    task automatic txn(input int s, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic we, input logic re,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic rdy_after, output logic [31:0] bt);
        logic seen;
        seen = 1'b0; lat = -1; bt = '0; rd = '0; er = 1'b0;
        @(posedge clk); #1;
        drive(s, addr, wdata, strb, we, re);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            bt[k] = (s == 0) ? a_busy : b_busy;
            if (((s == 0) ? a_ready : b_ready) === 1'b1) begin
                seen = 1'b1; lat = k;
                rd = (s == 0) ? a_rdata : b_rdata;
                er = (s == 0) ? a_err : b_err;
            end
        end
        @(posedge clk); #1;
        drive(s, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rdy_after = (s == 0) ? a_ready : b_ready;
        if (lat >= 0) bt[lat+1] = (s == 0) ? a_busy : b_busy;
    endtask

    task automatic test_reset();
        logic [31:0] rd, bt; logic er, ra; int lat;
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_tests++; if ({a_ready, a_err, a_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got ready/err/busy %b want 000", {a_ready, a_err, a_busy}); end
        n_tests++; if ({b_ready, b_err, b_busy, b_rdata} !== 35'h0) begin n_fail++; $display("FAIL reset_b: got %b/%h want 0", {b_ready, b_err, b_busy}, b_rdata); end
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        txn(0, 32'h8000_0100, 32'h0, 4'h0, 1'b0, 1'b1, rd, er, lat, ra, bt);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL reset_first_read_latency: got %0d want 3", lat); end
        n_tests++; if ((bt & 32'h1F) !== 32'h0E) begin n_fail++; $display("FAIL reset_first_read_busy: got %b want 01110", bt[4:0]); end
        // Contents of that word are unknown; keep the model's hold value coherent.
        last_rd[0] = rd;
    endtask

    task automatic test_full_word();
        logic [31:0] rd, bt, er_rd; logic er, ra, xe; int lat;
        txn(0, 32'h8000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b0, er_rd, xe);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL full_write_latency: got %0d want 3", lat); end
        n_tests++; if (ra !== 1'b0) begin n_fail++; $display("FAIL full_write_pulse_width: ready after pulse got %b want 0", ra); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL full_write_err: got %b want 0", er); end
        txn(0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b1, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b1, er_rd, xe);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL full_read_latency: got %0d want 3", lat); end
        n_tests++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL full_read_data: got %h want 12345678", rd); end
        n_tests++; if ((bt & 32'h1F) !== 32'h0E) begin n_fail++; $display("FAIL full_read_busy: got %b want 01110", bt[4:0]); end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] rd, bt, mrd; logic er, ra, xe; int lat;
        txn(0, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0, mrd, xe);
        txn(0, 32'h8000_0020, 32'h1122_3344, 4'b0101, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0020, 32'h1122_3344, 4'b0101, 1'b1, 1'b0, mrd, xe);
        n_tests++; if (rd !== mrd) begin n_fail++; $display("FAIL strobe_write_holds_rdata: got %h want %h", rd, mrd); end
        txn(0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b1, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b1, mrd, xe);
        n_tests++; if (rd !== 32'hAA22_CC44) begin n_fail++; $display("FAIL strobe_read: got %h want aa22cc44", rd); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, bt, mrd, addr; logic er, ra, xe, pick; int lat;
        for (int i = 0; i < 8; i++) begin
            addr = BASE + 32'(4 * i);
            txn(1, addr, $urandom, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
            model_txn(1, addr, 32'h0, 4'h0, 1'b0, 1'b0, mrd, xe);
            mem_m[1][i] = 32'hx;
        end
        // Re-write with known data so the model tracks exactly what was stored.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d = $urandom;
            addr = BASE + 32'(4 * i);
            txn(1, addr, d, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
            model_txn(1, addr, d, 4'hF, 1'b1, 1'b0, mrd, xe);
            n_tests++; if (lat != 1) begin n_fail++; $display("FAIL zero_wait_latency[%0d]: got %0d want 1", i, lat); end
        end
        n_tests++; if ((bt & 32'h7) !== 32'h2) begin n_fail++; $display("FAIL zero_wait_busy: got %b want 010", bt[2:0]); end
        addr = BASE + 32'(4 * $urandom_range(0, 7));
        @(posedge clk); #1;
        drive(1, addr, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            pick = 1'b0;
            n_tests++; if (b_ready !== 1'(k % 2 == 1)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, b_ready, (k % 2 == 1)); end
            if (k % 2 == 1) begin
                model_txn(1, addr, 32'h0, 4'h0, 1'b0, 1'b1, mrd, xe);
                n_tests++; if (b_rdata !== mrd) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", k, b_rdata, mrd); end
                pick = 1'b1;
            end
            @(posedge clk); #1;
            if (pick) begin
                addr = BASE + 32'(4 * $urandom_range(0, 7));
                b_addr = addr;
            end
        end
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid(input int d);
        logic [31:0] rd, bt, mrd, prior; logic er, ra, xe; int lat, rdy_cnt;
        prior = 32'h0BAD_F00D ^ 32'(d);
        txn(0, 32'h8000_0030, prior, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0030, prior, 4'hF, 1'b1, 1'b0, mrd, xe);
        rdy_cnt = 0;
        @(posedge clk); #1;
        drive(0, 32'h8000_0030, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
        for (int k = 0; k < d; k++) begin
            @(negedge clk); if (a_ready === 1'b1) rdy_cnt++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk); if (a_ready === 1'b1) rdy_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy[d=%0d]: got %b want 0", d, a_busy); end
        n_tests++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mid_rdata[d=%0d]: got %h want 0", d, a_rdata); end
        repeat (5) begin
            if (a_ready === 1'b1) rdy_cnt++;
            @(negedge clk);
        end
        n_tests++; if (rdy_cnt != 0) begin n_fail++; $display("FAIL reset_mid_no_ready[d=%0d]: got %0d pulses want 0", d, rdy_cnt); end
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        txn(0, 32'h8000_0030, 32'h0, 4'h0, 1'b0, 1'b1, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0030, 32'h0, 4'h0, 1'b0, 1'b1, mrd, xe);
        n_tests++; if (rd !== prior) begin n_fail++; $display("FAIL reset_mid_prior[d=%0d]: got %h want %h", d, rd, prior); end
    endtask

    task automatic test_bounds();
        logic [31:0] rd, bt, mrd, v0, v1; logic er, ra, xe; int lat;
        v0 = 32'h0F0F_1234; v1 = 32'hC0DE_4095;
        txn(0, 32'h8000_0000, v0, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_0000, v0, 4'hF, 1'b1, 1'b0, mrd, xe);
        txn(0, 32'h8000_3FFC, v1, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_3FFC, v1, 4'hF, 1'b1, 1'b0, mrd, xe);
        txn(0, 32'h8000_4000, 32'h0, 4'h0, 1'b0, 1'b1, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_4000, 32'h0, 4'h0, 1'b0, 1'b1, mrd, xe);
        n_tests++; if (rd !== (BOUNDS ? ERRW : v0)) begin n_fail++; $display("FAIL bounds_read_data: got %h want %h", rd, (BOUNDS ? ERRW : v0)); end
        n_tests++; if (er !== BOUNDS) begin n_fail++; $display("FAIL bounds_read_err: got %b want %b", er, BOUNDS); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL bounds_read_latency: got %0d want 3", lat); end
        txn(0, 32'h7FFF_FFFC, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
        model_txn(0, 32'h7FFF_FFFC, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0, mrd, xe);
        n_tests++; if (er !== BOUNDS) begin n_fail++; $display("FAIL bounds_write_err: got %b want %b", er, BOUNDS); end
        txn(0, 32'h8000_3FFC, 32'h0, 4'h0, 1'b0, 1'b1, rd, er, lat, ra, bt);
        model_txn(0, 32'h8000_3FFC, 32'h0, 4'h0, 1'b0, 1'b1, mrd, xe);
        n_tests++; if (rd !== (BOUNDS ? v1 : 32'h5555_AAAA)) begin n_fail++; $display("FAIL bounds_word4095: got %h want %h", rd, (BOUNDS ? v1 : 32'h5555_AAAA)); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL bounds_inrange_err: got %b want 0", er); end
    endtask

    task automatic test_random();
        logic [31:0] rd, bt, mrd, addr, d; logic er, ra, xe, we, re; logic [3:0] strb; int lat, op, alias_k;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            txn(0, BASE + 32'(4 * w), d, 4'hF, 1'b1, 1'b0, rd, er, lat, ra, bt);
            model_txn(0, BASE + 32'(4 * w), d, 4'hF, 1'b1, 1'b0, mrd, xe);
        end
        for (int i = 0; i < 60; i++) begin
            addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            alias_k = $urandom_range(0, 7);
            if (alias_k == 1) addr = addr + 32'(4 * DEPTH);
            else if (alias_k == 2) addr = addr + 32'(12 * DEPTH);
            else if (alias_k == 3) addr = addr - 32'(4 * DEPTH);
            op   = $urandom_range(1, 3);
            we   = (op != 2);
            re   = (op != 1);
            strb = 4'($urandom);
            d    = $urandom;
            txn(0, addr, d, strb, we, re, rd, er, lat, ra, bt);
            model_txn(0, addr, d, strb, we, re, mrd, xe);
            n_tests++; if (rd !== mrd) begin n_fail++; $display("FAIL rand_rdata[%0d] addr=%h op=%0d: got %h want %h", i, addr, op, rd, mrd); end
            n_tests++; if (er !== xe) begin n_fail++; $display("FAIL rand_err[%0d] addr=%h: got %b want %b", i, addr, er, xe); end
            n_tests++; if (lat != 3 || ra !== 1'b0) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat %0d after %b want 3 and 0", i, lat, ra); end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_strobes();
        test_zero_wait();
        test_reset_mid(1);
        test_reset_mid(2);
        test_bounds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
